node_coef_bank: RTL and testbench
=================================

NODE_COEF_BANK -- requirements
Module: node_coef_bank

Interface
REQ-001 Parameter NC, default 3: coefficients per node, bias included (previous-layer node count + 1); NC ≥ 2.
REQ-002 Word width SHALL be `n` from fixed_point.vh, two's-complement, `f` fraction bits.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset, sampled on rising clk edge.
REQ-005 Port we, input, 1: this node's c_we bit; serial coefficient load strobe.
REQ-006 Port din, input, n: coefficient bus word, valid whenever we=1.
REQ-007 Port dtb, input, 1: 0 = load/update into registers, 1 = drive registers onto bus.
REQ-008 Port upd_we, input, 1: this node's bp_we bit for the update path; sampled only while dtb=0.
REQ-009 Port upd_coef, input, NC*n: new coefficient vector, word k at [k*n +: n].
REQ-010 Port save_en, input, 1: this node's bp_we bit for readback; sampled only while dtb=1.
REQ-011 Port coef, output, NC*n: stored coefficients, word k at [k*n +: n]; word 0 = first word loaded.
REQ-012 Port dout, output, n: registered readback word.
REQ-013 Port e_out, output, 1: registered bus-drive enable, qualifies dout.
REQ-014 Port full, output, 1: NC words held since the last load start.
REQ-015 Port ovf, output, 1: sticky; a load word arrived while full.
REQ-016 Port save_done, output, 1: one-cycle pulse on the last readback word.

Function
REQ-017 FSM states: EMPTY, FILL, FULL, DRAIN.
REQ-018 Load start: we=1 and dtb=0 while we was 0 in the previous cycle. It SHALL clear the word count to 0, clear ovf, and store din as word 0 in the same cycle, from any state except DRAIN.
REQ-019 Each further cycle with we=1 and dtb=0 SHALL store din at index count, increment count, and stay in FILL.
REQ-020 When count reaches NC the FSM SHALL enter FULL, and full SHALL assert on the edge that stores word NC-1.
REQ-021 we=1 with dtb=0 in FULL, not a load start: the word SHALL be discarded, ovf set to 1, and contents unchanged.
REQ-022 we deasserted in FILL: the FSM SHALL hold FILL and keep count; the next we rise is a load start.
REQ-023 upd_we=1 with dtb=0 in FULL SHALL load all NC words from upd_coef in one cycle. In any other state upd_we SHALL be ignored.
REQ-024 we and upd_we both active: we takes priority and upd_we is ignored.
REQ-025 save_en=1 with dtb=1 in FULL SHALL enter DRAIN with read pointer 0.
REQ-026 Each DRAIN cycle with save_en=1 and dtb=1 SHALL register dout=word[ptr] and e_out=1, then increment ptr. This gives a latency of one cycle from save_en to the word on dout.
REQ-027 When ptr=NC-1 is read, save_done SHALL pulse with that word and the FSM SHALL return to FULL. Contents SHALL be preserved; readback is non-destructive.
REQ-028 save_en dropping in DRAIN SHALL pause: e_out=0, ptr held, dout held.
REQ-029 dtb falling in DRAIN SHALL abort: ptr cleared and FULL entered. we and upd_we SHALL be ignored during that cycle.
REQ-030 save_en in EMPTY or FILL SHALL be ignored, with e_out=0.
REQ-031 we while dtb=1 SHALL be ignored in every state.

Reset
REQ-032 On rst=1 at a clk edge: state EMPTY, all coefficient words 0, count 0, ptr 0, dout 0, e_out 0, full 0, ovf 0, save_done 0.
REQ-033 Reset mid-FILL or mid-DRAIN SHALL take precedence over every other input in that cycle.

Configuration
REQ-034 Macro COEF_READBACK_EN SHALL control the readback path.
REQ-035 With COEF_READBACK_EN defined, the DRAIN state and the dout, e_out and save_done behaviour SHALL be as specified above.
REQ-036 Without COEF_READBACK_EN, DRAIN SHALL be absent, save_en SHALL be ignored, and dout, e_out and save_done SHALL be tied to 0. All other behaviour SHALL be identical.

Verification
REQ-037 NC=3: reset, then we=1 for 3 cycles with din 0x100,0x200,0x300 -> coef words 0x100,0x200,0x300; full=1 after the third edge; ovf=0.
REQ-038 From FULL: a 4th we cycle with din 0x400 -> ovf=1 and coef unchanged; we low then high with din 0x010 -> ovf=0, full=0, word0=0x010.
REQ-039 From FULL (0x100,0x200,0x300): dtb=1, save_en=1 for 3 cycles -> e_out=1 with dout 0x100,0x200,0x300 on the 3 following cycles; save_done with 0x300; state back to FULL.
REQ-040 Drain paused one cycle after the first word -> no e_out for that cycle, then 0x200 follows. Drain again, with dtb dropped after the first word -> FULL, and the next drain restarts at 0x100.
REQ-041 FULL with upd_we=1, dtb=0, upd_coef={0x3,0x2,0x1} -> coef words 0x1,0x2,0x3 the next cycle. The same cycle with we=1 -> upd ignored.
REQ-042 rst asserted mid-FILL after 1 word -> all outputs 0 next cycle, and the following we starts at word 0.

Source files
------------

// File: rtl/node_coef_bank.sv
// Per-node coefficient register bank: serial load, single-cycle bulk update and optional serial readback.
// Optional feature macro: COEF_READBACK_EN enables the DRAIN readback path (dout/e_out/save_done).
module node_coef_bank #(
  parameter int NC = 3,
  parameter int N  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N-1:0]    din,
  input  logic            dtb,
  input  logic            upd_we,
  input  logic [NC*N-1:0] upd_coef,
  input  logic            save_en,
  output logic [NC*N-1:0] coef,
  output logic [N-1:0]    dout,
  output logic            e_out,
  output logic            full,
  output logic            ovf,
  output logic            save_done
);

  localparam int CW = $clog2(NC + 1);
  localparam int PW = $clog2(NC);

`ifdef COEF_READBACK_EN
  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} state_t;
`else
  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  coef_q [NC];
  logic [N-1:0]  coef_d [NC];
  logic          ovf_q, ovf_d;
  logic          we_q;
  logic          weActive;
  logic          loadStart;
  logic          startLoad;

`ifdef COEF_READBACK_EN
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          eOut_q, eOut_d;
  logic          saveDone_q, saveDone_d;
`else
  logic          unusedSaveEn;
  assign unusedSaveEn = save_en;
`endif

  assign weActive  = we && !dtb;
  assign loadStart = weActive && !we_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    startLoad = 1'b0;
    for (int k = 0; k < NC; k++) coef_d[k] = coef_q[k];
`ifdef COEF_READBACK_EN
    ptr_d      = ptr_q;
    dout_d     = dout_q;
    eOut_d     = 1'b0;
    saveDone_d = 1'b0;
`endif

    case (state_q)
      EMPTY: begin
        if (weActive) startLoad = 1'b1;
      end
      FILL: begin
        if (loadStart) begin
          startLoad = 1'b1;
        end else if (weActive) begin
          for (int k = 0; k < NC; k++)
            if (CW'(k) == count_q) coef_d[k] = din;
          count_d = count_q + CW'(1);
          if (count_q == CW'(NC - 1)) state_d = FULL;
        end
      end
      FULL: begin
        // A fresh load start wins over everything; a continued strobe only flags overflow.
        if (loadStart) begin
          startLoad = 1'b1;
        end else if (weActive) begin
          ovf_d = 1'b1;
        end else if (upd_we && !dtb) begin
          for (int k = 0; k < NC; k++) coef_d[k] = upd_coef[k*N +: N];
        end
`ifdef COEF_READBACK_EN
        else if (save_en && dtb) begin
          dout_d  = coef_q[0];
          eOut_d  = 1'b1;
          ptr_d   = PW'(1);
          state_d = DRAIN;
        end
`endif
      end
`ifdef COEF_READBACK_EN
      DRAIN: begin
        // Losing dtb aborts the readback; the load and update strobes are dropped this cycle.
        if (!dtb) begin
          ptr_d   = '0;
          state_d = FULL;
        end else if (save_en) begin
          for (int k = 0; k < NC; k++)
            if (PW'(k) == ptr_q) dout_d = coef_q[k];
          eOut_d = 1'b1;
          if (ptr_q == PW'(NC - 1)) begin
            saveDone_d = 1'b1;
            ptr_d      = '0;
            state_d    = FULL;
          end else begin
            ptr_d = ptr_q + PW'(1);
          end
        end
      end
`endif
      default: state_d = EMPTY;
    endcase

    if (startLoad) begin
      coef_d[0] = din;
      count_d   = CW'(1);
      ovf_d     = 1'b0;
      state_d   = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      for (int k = 0; k < NC; k++) coef_q[k] <= '0;
`ifdef COEF_READBACK_EN
      ptr_q      <= '0;
      dout_q     <= '0;
      eOut_q     <= 1'b0;
      saveDone_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      we_q    <= we;
      for (int k = 0; k < NC; k++) coef_q[k] <= coef_d[k];
`ifdef COEF_READBACK_EN
      ptr_q      <= ptr_d;
      dout_q     <= dout_d;
      eOut_q     <= eOut_d;
      saveDone_q <= saveDone_d;
`endif
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_coef
    assign coef[g*N +: N] = coef_q[g];
  end

  assign ovf = ovf_q;

`ifdef COEF_READBACK_EN
  assign full      = (state_q == FULL) || (state_q == DRAIN);
  assign dout      = dout_q;
  assign e_out     = eOut_q;
  assign save_done = saveDone_q;
`else
  assign full      = (state_q == FULL);
  assign dout      = '0;
  assign e_out     = 1'b0;
  assign save_done = 1'b0;
`endif

endmodule

// File: tb/tb_node_coef_bank.sv
// Table-driven self-checking bench for node_coef_bank (NC=3, 16-bit words).
// Readback expectations follow COEF_READBACK_EN; without it dout/e_out/save_done must stay 0.
module tb_node_coef_bank;

  localparam int NC = 3;
  localparam int N  = 16;
`ifdef COEF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, we, dtb, upd_we, save_en;
  logic [N-1:0]    din;
  logic [NC*N-1:0] upd_coef;
  logic [NC*N-1:0] coef;
  logic [N-1:0]    dout;
  logic            e_out, full, ovf, save_done;

  int checks = 0;
  int errors = 0;

  node_coef_bank #(.NC(NC), .N(N)) dut (
    .clk(clk), .rst(rst), .we(we), .din(din), .dtb(dtb),
    .upd_we(upd_we), .upd_coef(upd_coef), .save_en(save_en),
    .coef(coef), .dout(dout), .e_out(e_out), .full(full),
    .ovf(ovf), .save_done(save_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst, we;
    logic [N-1:0]    din;
    logic            dtb, updWe;
    logic [NC*N-1:0] updCoef;
    logic            saveEn;
    logic [NC*N-1:0] expCoef;
    logic [N-1:0]    expDout;
    logic            expEOut, expFull, expOvf, expSaveDone;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [NC*N-1:0] pk(input logic [N-1:0] w0, input logic [N-1:0] w1,
                                         input logic [N-1:0] w2);
    return {w2, w1, w0};
  endfunction

  function automatic logic [N-1:0] rbw(input logic [N-1:0] w);
    return RB ? w : '0;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic [N-1:0] d,
                              input logic t, input logic u, input logic [NC*N-1:0] uc,
                              input logic s, input logic [NC*N-1:0] ec, input logic [N-1:0] ed,
                              input logic ee, input logic ef, input logic eo, input logic es);
    vec_t v;
    v.rst = r; v.we = w; v.din = d; v.dtb = t; v.updWe = u; v.updCoef = uc; v.saveEn = s;
    v.expCoef = ec; v.expDout = ed; v.expEOut = ee; v.expFull = ef; v.expOvf = eo;
    v.expSaveDone = es;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; we = v.we; din = v.din; dtb = v.dtb;
    upd_we = v.updWe; upd_coef = v.updCoef; save_en = v.saveEn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string what, input int idx, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", what, idx, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    checkOutput("coef",      idx, 64'(coef),      64'(v.expCoef));
    checkOutput("dout",      idx, 64'(dout),      64'(v.expDout));
    checkOutput("e_out",     idx, 64'(e_out),     64'(v.expEOut));
    checkOutput("full",      idx, 64'(full),      64'(v.expFull));
    checkOutput("ovf",       idx, 64'(ovf),       64'(v.expOvf));
    checkOutput("save_done", idx, 64'(save_done), 64'(v.expSaveDone));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NC*N-1:0] c;
    rst = 1'b1; we = 1'b0; din = '0; dtb = 1'b0; upd_we = 1'b0; upd_coef = '0; save_en = 1'b0;
    c = pk(16'h100, 16'h200, 16'h300);

    // rst we din dtb upd updCoef save | coef dout e_out full ovf save_done
    vecs.push_back(mk(1, 0, 16'h000, 0, 0, '0, 0, pk(0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h100, 0, 0, '0, 0, pk(16'h100, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h200, 0, 0, '0, 0, pk(16'h100, 16'h200, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h300, 0, 0, '0, 0, c, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h400, 0, 0, '0, 0, c, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 16'h000, 0, 0, '0, 0, c, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 16'h010, 0, 0, '0, 0, pk(16'h010, 16'h200, 16'h300), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h020, 0, 0, '0, 0, pk(16'h010, 16'h020, 16'h300), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h030, 0, 0, '0, 0, pk(16'h010, 16'h020, 16'h030), 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h000, 0, 0, '0, 0, pk(16'h010, 16'h020, 16'h030), 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h100, 0, 0, '0, 0, pk(16'h100, 16'h020, 16'h030), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h200, 0, 0, '0, 0, pk(16'h100, 16'h200, 16'h030), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h300, 0, 0, '0, 0, c, 0, 0, 1, 0, 0));
    // full readback, then pause, then abort and restart
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h100), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h200), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h300), RB, 1, 0, RB));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 0, c, rbw(16'h300), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h100), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 0, c, rbw(16'h100), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h200), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h300), RB, 1, 0, RB));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h100), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, '0, 0, c, rbw(16'h100), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h100), RB, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, '0, 0, c, rbw(16'h100), 0, 1, 0, 0));
    // bulk update, and a load start that overrides a simultaneous update
    vecs.push_back(mk(0, 0, 0, 0, 1, pk(16'h1, 16'h2, 16'h3), 0,
                      pk(16'h1, 16'h2, 16'h3), rbw(16'h100), 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h055, 0, 1, pk(16'h9, 16'h9, 16'h9), 0,
                      pk(16'h055, 16'h2, 16'h3), rbw(16'h100), 0, 0, 0, 0));
    // reset mid-fill, then restart at word 0 with ignored update/readback/dtb-load attempts
    vecs.push_back(mk(1, 1, 16'h066, 0, 0, '0, 0, pk(0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0AB, 0, 0, '0, 0, pk(16'h0AB, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h000, 0, 1, pk(16'h5, 16'h5, 16'h5), 0,
                      pk(16'h0AB, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h000, 1, 0, '0, 1, pk(16'h0AB, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0CD, 1, 0, '0, 0, pk(16'h0AB, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0CD, 0, 0, '0, 0, pk(16'h0AB, 16'h0CD, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0EF, 0, 0, '0, 0, pk(16'h0AB, 16'h0CD, 16'h0EF), 0, 0, 1, 0, 0));

    foreach (vecs[i]) runVec(vecs[i], i);

    // Abort cycle with load and update strobes: with readback they are dropped,
    // without readback the bank sits in FULL and sees a genuine load start.
    c = pk(16'h0AB, 16'h0CD, 16'h0EF);
    runVec(mk(0, 0, 0, 1, 0, '0, 1, c, rbw(16'h0AB), RB, 1, 0, 0), 100);
    runVec(mk(0, 1, 16'h111, 0, 1, pk(16'h7, 16'h7, 16'h7), 0,
              RB ? c : pk(16'h111, 16'h0CD, 16'h0EF), rbw(16'h0AB), 0, RB, 0, 0), 101);
    runVec(mk(0, 0, 0, 0, 0, '0, 0,
              RB ? c : pk(16'h111, 16'h0CD, 16'h0EF), rbw(16'h0AB), 0, RB, 0, 0), 102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
